// File: rtl/axi_timer_pkg.sv
// rtl/axi_timer_pkg.sv - shared types and constants for the multi-channel AXI timer
//
// Contents: register offsets, channel block layout, AXI request/response
// structs, pending-request record, control-field struct, register selector
// and the byte-strobe merge helper.

package axi_timer_pkg;

  localparam int ID_W    = 4;
  localparam int MAX_CMP = 8;

  localparam logic [15:0] OFF_MTIME_LO   = 16'h0000;
  localparam logic [15:0] OFF_MTIME_HI   = 16'h0004;
  localparam logic [15:0] OFF_CTRL       = 16'h0008;
  localparam logic [15:0] OFF_PRESC      = 16'h000C;
  localparam logic [15:0] OFF_IRQ_STATUS = 16'h0010;
  localparam logic [15:0] OFF_IRQ_EN     = 16'h0014;
  localparam logic [15:0] CH_BASE        = 16'h0040;
  localparam logic [15:0] CH_STRIDE      = 16'h0010;
  localparam logic [15:0] CH_END         = CH_BASE + 16'(MAX_CMP) * CH_STRIDE;

  // Offsets inside one channel block
  localparam logic [3:0] OFF_CMP_LO = 4'h0;
  localparam logic [3:0] OFF_CMP_HI = 4'h4;
  localparam logic [3:0] OFF_PERIOD = 4'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic en;
    logic clr;
  } ctrl_t;

  typedef struct packed {
    logic            vld;
    logic [15:0]     addr;
    logic [ID_W-1:0] id;
  } pend_t;

  typedef enum logic [3:0] {
    SEL_NONE,
    SEL_MTIME_LO,
    SEL_MTIME_HI,
    SEL_CTRL,
    SEL_PRESC,
    SEL_STATUS,
    SEL_IRQ_EN,
    SEL_CMP_LO,
    SEL_CMP_HI,
    SEL_PERIOD
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] ch;
  } reg_dec_t;

  typedef struct packed {
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic            awvalid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            bready;
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic            arvalid;
    logic            rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic            awready;
    logic            wready;
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            arready;
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
  } s_axi_miso_t;

  // Replace only the bytes whose strobe bit is set
  function automatic logic [31:0] wmerge(input logic [31:0] old_val,
                                         input logic [31:0] new_val,
                                         input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_timer_presc.sv
// rtl/axi_timer_presc.sv - prescaler producing the mtime tick
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en_i      - counting enable; when low the counter is frozen
//   presc_i   - terminal count; tick fires when the counter equals it
//   clr_i     - returns the counter to 0 (CLR or a PRESC write)
//   tick_o    - one-cycle tick advancing mtime

module axi_timer_presc #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  logic               clr_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == presc_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/axi_timer_mc.sv
// rtl/axi_timer_mc.sv - multi-channel prescaled 64-bit machine timer, AXI4 slave
//
// Build option: define AXI_TIMER_AUTORELOAD_EN to add the per-channel PERIOD
// register and compare auto-reload; otherwise PERIOD offsets are unmapped.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   axi_mosi         - AXI4 slave request channels (AW, W, B ready, AR, R ready)
//   axi_miso         - AXI4 slave response channels
//   timer_irq_o      - per-channel level interrupt (status & IRQ_EN)
//   timer_irq_any_o  - OR of timer_irq_o

module axi_timer_mc
  import axi_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          NUM_CMP   = 2,
  parameter int          PRESC_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  s_axi_mosi_t        axi_mosi,
  output s_axi_miso_t        axi_miso,
  output logic [NUM_CMP-1:0] timer_irq_o,
  output logic               timer_irq_any_o
);

  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        cmp_q [NUM_CMP];
  logic [63:0]        cmp_d [NUM_CMP];
`ifdef AXI_TIMER_AUTORELOAD_EN
  logic [31:0]        period_q [NUM_CMP];
  logic [31:0]        period_d [NUM_CMP];
`endif
  logic               en_q, en_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [NUM_CMP-1:0] irq_en_q, irq_en_d;
  logic [NUM_CMP-1:0] status;

  pend_t              aw_q, aw_d, ar_q, ar_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic [ID_W-1:0]    bid_q, bid_d;

  logic               tick, wr_fire, presc_wr, awready, arready;
  ctrl_t              ctrl_w;
  reg_dec_t           wdec, rdec;
  logic [31:0]        rdata;
  logic               unused_ok;

  assign unused_ok = ^{axi_mosi.awaddr[31:16], axi_mosi.araddr[31:16], axi_mosi.wlast};

  function automatic reg_dec_t decode(input logic [15:0] off);
    reg_dec_t d;
    d.sel = SEL_NONE;
    d.ch  = 3'((off - CH_BASE) >> 4);
    if (off[1:0] == 2'b00) begin
      case (off)
        OFF_MTIME_LO:   d.sel = SEL_MTIME_LO;
        OFF_MTIME_HI:   d.sel = SEL_MTIME_HI;
        OFF_CTRL:       d.sel = SEL_CTRL;
        OFF_PRESC:      d.sel = SEL_PRESC;
        OFF_IRQ_STATUS: d.sel = SEL_STATUS;
        OFF_IRQ_EN:     d.sel = SEL_IRQ_EN;
        default: begin
          if (off >= CH_BASE && off < CH_END && 32'(d.ch) < NUM_CMP) begin
            case (off[3:0])
              OFF_CMP_LO: d.sel = SEL_CMP_LO;
              OFF_CMP_HI: d.sel = SEL_CMP_HI;
`ifdef AXI_TIMER_AUTORELOAD_EN
              OFF_PERIOD: d.sel = SEL_PERIOD;
`endif
              default:    d.sel = SEL_NONE;
            endcase
          end
        end
      endcase
    end
    return d;
  endfunction

  assign wdec    = decode(aw_q.addr);
  assign rdec    = decode(ar_q.addr);
  // W is only accepted once AW is latched, so same-cycle AW+W takes AW first
  assign wr_fire = aw_q.vld & axi_mosi.wvalid;
  assign awready = ~aw_q.vld & ~bvalid_q;
  assign arready = ~ar_q.vld;

  axi_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_q),
    .presc_i (presc_q),
    .clr_i   (ctrl_w.clr | presc_wr),
    .tick_o  (tick)
  );

  always_comb begin
    status = '0;
    for (int i = 0; i < NUM_CMP; i++) status[i] = (mtime_q >= cmp_q[i]);
  end

  assign timer_irq_o     = status & irq_en_q;
  assign timer_irq_any_o = |timer_irq_o;

  // Register write path
  always_comb begin
    mtime_d  = tick ? mtime_q + 64'd1 : mtime_q;
    en_d     = en_q;
    presc_d  = presc_q;
    irq_en_d = irq_en_q;
    cmp_d    = cmp_q;
`ifdef AXI_TIMER_AUTORELOAD_EN
    period_d = period_q;
`endif
    ctrl_w   = '0;
    presc_wr = 1'b0;

    if (wr_fire) begin
      case (wdec.sel)
        SEL_MTIME_LO: mtime_d = {mtime_q[63:32], wmerge(mtime_q[31:0], axi_mosi.wdata, axi_mosi.wstrb)};
        SEL_MTIME_HI: mtime_d = {wmerge(mtime_q[63:32], axi_mosi.wdata, axi_mosi.wstrb), mtime_q[31:0]};
        SEL_CTRL: begin
          ctrl_w.en  = axi_mosi.wstrb[0] ? axi_mosi.wdata[0] : en_q;
          ctrl_w.clr = axi_mosi.wstrb[0] & axi_mosi.wdata[1];
          en_d       = ctrl_w.en;
        end
        SEL_PRESC: begin
          presc_d  = PRESC_W'(wmerge(32'(presc_q), axi_mosi.wdata, axi_mosi.wstrb));
          presc_wr = 1'b1;
        end
        SEL_IRQ_EN: irq_en_d = NUM_CMP'(wmerge(32'(irq_en_q), axi_mosi.wdata, axi_mosi.wstrb));
        default: ;
      endcase
    end

    for (int i = 0; i < NUM_CMP; i++) begin
`ifdef AXI_TIMER_AUTORELOAD_EN
      if (status[i] && period_q[i] != 32'd0 && tick) begin
        cmp_d[i] = cmp_q[i] + {32'd0, period_q[i]};
      end
      if (wr_fire && wdec.ch == 3'(i) && wdec.sel == SEL_PERIOD) begin
        period_d[i] = wmerge(period_q[i], axi_mosi.wdata, axi_mosi.wstrb);
      end
`endif
      // A software compare write overrides any reload computed above
      if (wr_fire && wdec.ch == 3'(i) && wdec.sel == SEL_CMP_LO) begin
        cmp_d[i] = {cmp_q[i][63:32], wmerge(cmp_q[i][31:0], axi_mosi.wdata, axi_mosi.wstrb)};
      end
      if (wr_fire && wdec.ch == 3'(i) && wdec.sel == SEL_CMP_HI) begin
        cmp_d[i] = {wmerge(cmp_q[i][63:32], axi_mosi.wdata, axi_mosi.wstrb), cmp_q[i][31:0]};
      end
    end

    if (ctrl_w.clr) mtime_d = '0;
  end

  // Handshake bookkeeping: one outstanding write and one outstanding read
  always_comb begin
    aw_d     = aw_q;
    ar_d     = ar_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    if (axi_mosi.awvalid && awready) begin
      aw_d.vld  = 1'b1;
      aw_d.addr = axi_mosi.awaddr[15:0] - BASE_ADDR[15:0];
      aw_d.id   = axi_mosi.awid;
    end
    if (wr_fire) begin
      aw_d.vld = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = (wdec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
      bid_d    = aw_q.id;
    end else if (bvalid_q && axi_mosi.bready) begin
      bvalid_d = 1'b0;
    end
    if (axi_mosi.arvalid && arready) begin
      ar_d.vld  = 1'b1;
      ar_d.addr = axi_mosi.araddr[15:0] - BASE_ADDR[15:0];
      ar_d.id   = axi_mosi.arid;
    end else if (ar_q.vld && axi_mosi.rready) begin
      ar_d.vld = 1'b0;
    end
  end

  // Read data follows the live registers for as long as rvalid is held
  always_comb begin
    rdata = '0;
    case (rdec.sel)
      SEL_MTIME_LO: rdata = mtime_q[31:0];
      SEL_MTIME_HI: rdata = mtime_q[63:32];
      SEL_CTRL:     rdata = {31'd0, en_q};
      SEL_PRESC:    rdata = 32'(presc_q);
      SEL_STATUS:   rdata = 32'(status);
      SEL_IRQ_EN:   rdata = 32'(irq_en_q);
      SEL_CMP_LO, SEL_CMP_HI: begin
        for (int i = 0; i < NUM_CMP; i++) begin
          if (rdec.ch == 3'(i)) rdata = (rdec.sel == SEL_CMP_LO) ? cmp_q[i][31:0] : cmp_q[i][63:32];
        end
      end
`ifdef AXI_TIMER_AUTORELOAD_EN
      SEL_PERIOD: begin
        for (int i = 0; i < NUM_CMP; i++) begin
          if (rdec.ch == 3'(i)) rdata = period_q[i];
        end
      end
`endif
      default: rdata = '0;
    endcase
    if (!ar_q.vld) rdata = '0;
  end

  always_comb begin
    axi_miso         = '0;
    axi_miso.awready = awready;
    axi_miso.wready  = aw_q.vld;
    axi_miso.bid     = bid_q;
    axi_miso.bresp   = bresp_q;
    axi_miso.bvalid  = bvalid_q;
    axi_miso.arready = arready;
    axi_miso.rid     = ar_q.id;
    axi_miso.rdata   = rdata;
    axi_miso.rresp   = (ar_q.vld && rdec.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
    axi_miso.rlast   = ar_q.vld;
    axi_miso.rvalid  = ar_q.vld;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q  <= '0;
      en_q     <= 1'b1;
      presc_q  <= '0;
      irq_en_q <= '1;
      for (int i = 0; i < NUM_CMP; i++) begin
        cmp_q[i] <= '1;
`ifdef AXI_TIMER_AUTORELOAD_EN
        period_q[i] <= '0;
`endif
      end
      aw_q     <= '0;
      ar_q     <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      bid_q    <= '0;
    end else begin
      mtime_q  <= mtime_d;
      en_q     <= en_d;
      presc_q  <= presc_d;
      irq_en_q <= irq_en_d;
      cmp_q    <= cmp_d;
`ifdef AXI_TIMER_AUTORELOAD_EN
      period_q <= period_d;
`endif
      aw_q     <= aw_d;
      ar_q     <= ar_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
    end
  end

endmodule

// File: tb/tb_axi_timer_mc.sv
// tb/tb_axi_timer_mc.sv - directed self-checking bench for axi_timer_mc

module tb_axi_timer_mc;
  import axi_timer_pkg::*;

  localparam int NUM_CMP = 2;
  localparam int LIM     = 50;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  s_axi_mosi_t        mosi;
  s_axi_miso_t        miso;
  logic [NUM_CMP-1:0] irq;
  logic               irq_any;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int w_cyc, r_cyc, rst_cyc, wc, t1, n;
  logic [31:0] v1, v2, d;
  logic [1:0]  resp;
  logic [3:0]  id;

  axi_timer_mc #(.BASE_ADDR(32'h0), .NUM_CMP(NUM_CMP), .PRESC_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .axi_mosi        (mosi),
    .axi_miso        (miso),
    .timer_irq_o     (irq),
    .timer_irq_any_o (irq_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [3:0] wid, output logic [1:0] bresp, output logic [3:0] bid);
    int k;
    @(negedge clk);
    mosi.awaddr = {16'h0, addr}; mosi.awid = wid; mosi.awvalid = 1'b1;
    k = 0; while (!miso.awready && k < LIM) begin @(negedge clk); k++; end
    check("aw_wait", 64'(k < LIM), 1);
    @(posedge clk); @(negedge clk);
    mosi.awvalid = 1'b0; mosi.wdata = data; mosi.wstrb = strb; mosi.wlast = 1'b1; mosi.wvalid = 1'b1;
    k = 0; while (!miso.wready && k < LIM) begin @(negedge clk); k++; end
    check("w_wait", 64'(k < LIM), 1);
    @(posedge clk); @(negedge clk);
    w_cyc = cyc; mosi.wvalid = 1'b0; mosi.bready = 1'b1;
    k = 0; while (!miso.bvalid && k < LIM) begin @(negedge clk); k++; end
    check("b_wait", 64'(k < LIM), 1);
    bresp = miso.bresp; bid = miso.bid;
    @(posedge clk); @(negedge clk);
    mosi.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] addr, input logic [3:0] rid_in,
                          output logic [31:0] data, output logic [1:0] rresp, output logic [3:0] rid);
    int k;
    @(negedge clk);
    mosi.araddr = {16'h0, addr}; mosi.arid = rid_in; mosi.arvalid = 1'b1;
    k = 0; while (!miso.arready && k < LIM) begin @(negedge clk); k++; end
    check("ar_wait", 64'(k < LIM), 1);
    @(posedge clk); @(negedge clk);
    mosi.arvalid = 1'b0;
    k = 0; while (!miso.rvalid && k < LIM) begin @(negedge clk); k++; end
    check("r_wait", 64'(k < LIM), 1);
    data = miso.rdata; rresp = miso.rresp; rid = miso.rid; r_cyc = cyc;
    mosi.rready = 1'b1;
    @(posedge clk); @(negedge clk);
    mosi.rready = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data);
    logic [1:0] br; logic [3:0] bi;
    axi_write(addr, data, 4'hF, 4'h0, br, bi);
    check("wr_resp", br, RESP_OKAY);
  endtask

  task automatic rd(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] rdv; logic [1:0] rr; logic [3:0] ri;
    axi_read(addr, 4'h0, rdv, rr, ri);
    check(tag, rdv, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    mosi = '0;
    repeat (3) @(negedge clk);
    check("rst_awready", miso.awready, 1);
    check("rst_arready", miso.arready, 1);
    check("rst_wready", miso.wready, 0);
    check("rst_bvalid", miso.bvalid, 0);
    check("rst_rvalid", miso.rvalid, 0);
    check("rst_ids", {miso.bid, miso.rid}, 0);
    check("rst_irq", irq, 0);
    rst = 1'b0; rst_cyc = cyc;

    // free-running count with PRESC=0
    axi_read(OFF_MTIME_LO, 4'h0, v1, resp, id); t1 = r_cyc;
    check("mtime_first", v1, 64'(r_cyc - rst_cyc));
    repeat (10) @(negedge clk);
    axi_read(OFF_MTIME_LO, 4'h0, v2, resp, id);
    check("mtime_delta", v2 - v1, 64'(r_cyc - t1));
    rd("status_rst", OFF_IRQ_STATUS, 32'h0);
    rd("ctrl_rst", OFF_CTRL, 32'h1);
    rd("irq_en_rst", OFF_IRQ_EN, 32'h3);
    rd("cmp1_hi_rst", 16'h0054, 32'hFFFF_FFFF);
    rd("presc_rst", OFF_PRESC, 32'h0);
    check("irq_idle", irq, 0);

    // prescaler 3: match at 4*0x20 cycles after CLR
    wr(OFF_PRESC, 32'd3);
    wr(16'h0040, 32'h20);
    wr(16'h0044, 32'h0);
    wr(OFF_CTRL, 32'h3);
    wc = w_cyc;
    n = 0; while (!irq[0] && n < 400) begin @(negedge clk); n++; end
    check("presc_irq_delay", 64'(cyc - wc), 128);
    check("irq1_low", irq[1], 0);
    rd("presc_rb", OFF_PRESC, 32'd3);
    rd("ctrl_clr_reads0", OFF_CTRL, 32'h1);

    // masking
    wr(16'h0050, 32'h10);
    wr(16'h0054, 32'h0);
    wr(OFF_IRQ_EN, 32'h2);
    rd("status_both", OFF_IRQ_STATUS, 32'h3);
    check("irq_masked", irq, 2'b10);
    check("irq_any_on", irq_any, 1);
    wr(OFF_IRQ_EN, 32'h0);
    check("irq_any_off", irq_any, 0);

    // wrap of mtime, with a byte-strobe write on the way
    wr(OFF_CTRL, 32'h0);
    wr(OFF_PRESC, 32'h0);
    wr(OFF_MTIME_LO, 32'hFFFF_FFFF);
    wr(OFF_MTIME_HI, 32'hFFFF_FFFF);
    axi_write(OFF_MTIME_LO, 32'h0000_1200, 4'b0010, 4'h0, resp, id);
    rd("wstrb_merge", OFF_MTIME_LO, 32'hFFFF_12FF);
    wr(OFF_MTIME_LO, 32'hFFFF_FFFF);
    wr(16'h0040, 32'hFFFF_FFFF);
    wr(16'h0044, 32'hFFFF_FFFF);
    wr(OFF_IRQ_EN, 32'h1);
    rd("mtime_frozen", OFF_MTIME_LO, 32'hFFFF_FFFF);
    check("irq_at_max", irq, 2'b01);
    wr(OFF_CTRL, 32'h1);
    wc = w_cyc;
    rd("wrap_hi", OFF_MTIME_HI, 32'h0);
    axi_read(OFF_MTIME_LO, 4'h0, d, resp, id);
    check("wrap_lo", d, 64'(r_cyc - wc - 1));
    check("irq_after_wrap", irq, 2'b00);

    // error responses, back-pressured B, id echo
    @(negedge clk);
    mosi.awaddr = 32'h3C; mosi.awid = 4'h5; mosi.awvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    mosi.awvalid = 1'b0; mosi.wdata = 32'h1234; mosi.wstrb = 4'hF; mosi.wvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    mosi.wvalid = 1'b0;
    mosi.awaddr = 32'h14; mosi.awid = 4'h3; mosi.awvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bvalid_held", miso.bvalid, 1);
      check("aw_blocked", miso.awready, 0);
      @(negedge clk);
    end
    check("bid_echo", miso.bid, 4'h5);
    check("bresp_slverr", miso.bresp, RESP_SLVERR);
    mosi.awvalid = 1'b0; mosi.bready = 1'b1;
    @(posedge clk); @(negedge clk);
    mosi.bready = 1'b0;
    check("bvalid_clear", miso.bvalid, 0);
    axi_read(16'h0060, 4'hA, d, resp, id);
    check("rd_ch_oob_data", d, 0);
    check("rd_ch_oob_resp", resp, RESP_SLVERR);
    check("rid_echo", id, 4'hA);
    axi_read(16'h0002, 4'h0, d, resp, id);
    check("rd_unaligned_resp", resp, RESP_SLVERR);

`ifdef AXI_TIMER_AUTORELOAD_EN
    wr(OFF_CTRL, 32'h2);
    wr(16'h0040, 32'd50);
    wr(16'h0044, 32'h0);
    wr(16'h0048, 32'd100);
    rd("period_rb", 16'h0048, 32'd100);
    wr(OFF_IRQ_EN, 32'h1);
    wr(OFF_CTRL, 32'h1);
    wc = w_cyc;
    n = 0; while (!irq[0] && n < 300) begin @(negedge clk); n++; end
    t1 = cyc;
    check("reload_first", 64'(t1 - wc), 50);
    @(negedge clk);
    check("reload_pulse", irq[0], 0);
    rd("cmp_150", 16'h0040, 32'd150);
    n = 0; while (!irq[0] && n < 300) begin @(negedge clk); n++; end
    check("reload_period", 64'(cyc - t1), 100);
    rd("cmp_250", 16'h0040, 32'd250);
`else
    axi_read(16'h0048, 4'h0, d, resp, id);
    check("period_unmapped_resp", resp, RESP_SLVERR);
    check("period_unmapped_data", d, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
